// File: rtl/spi_shifter_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transfer engine: the data_width codes, a
// helper that turns a width code into a bit count, and the FSM state type.
// Ports: none (package).
// ----------------------------------------------------------------------------
package spi_pkg;

   // Width codes as written by software into the control register.
   // Code 2'b11 is reserved and treated like W8.
   localparam logic [1:0] W8  = 2'b00;
   localparam logic [1:0] W32 = 2'b01;
   localparam logic [1:0] W16 = 2'b10;

   // Number of bits moved by one transfer for a given width code.
   function automatic logic [5:0] nbits(input logic [1:0] code);
      case (code)
         W32:     nbits = 6'd32;
         W16:     nbits = 6'd16;
         default: nbits = 6'd8;
      endcase
   endfunction

   // IDLE waits for start, LOW is the sclk=0 half period, HIGH the sclk=1 one.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOW  = 2'b01,
      HIGH = 2'b10
   } state_e;

endpackage

// File: rtl/spi_shifter_if.sv
// ----------------------------------------------------------------------------
// spi_shifter_if
// Bundles the request side (start, transmit word, control snapshot), the
// result side (data_rx, rdy) and the serial pins (sclk, mosi, miso).
// Modports:
//   master - the register block / bench: drives the request and miso.
//   slave  - the shifter: consumes the request, drives result and sclk/mosi.
// ----------------------------------------------------------------------------
interface spi_shifter_if;
   import spi_pkg::*;

   logic        fast;
   logic [1:0]  data_width;
   logic        msbyte_first;
   logic        start;
   logic [31:0] data_tx;
   logic [31:0] data_rx;
   logic        rdy;
   logic        sclk;
   logic        mosi;
   logic        miso;

   modport master (
      output fast, data_width, msbyte_first, start, data_tx, miso,
      input  data_rx, rdy, sclk, mosi
   );

   modport slave (
      input  fast, data_width, msbyte_first, start, data_tx, miso,
      output data_rx, rdy, sclk, mosi
   );

endinterface

// File: rtl/spi_shifter_byte_order.sv
// ----------------------------------------------------------------------------
// spi_byte_order
// Purely combinational byte reorder between a register-layout word and the
// uniform shift image, where the first bit on the wire sits in bit 31 and the
// active bits occupy the top of the image.
//   INVERSE = 0 : word  -> image (transmit side, before shifting out)
//   INVERSE = 1 : image -> word  (receive side, after shifting in)
// Ports:
//   width_i     - width code (W8/W16/W32)
//   msbFirst_i  - 1 = top byte of the active width travels first
//   word_i      - input word (register layout or image, depending on INVERSE)
//   word_o      - reordered output, zero outside the active bits
// ----------------------------------------------------------------------------
module spi_byte_order
   import spi_pkg::*;
#(
   parameter bit INVERSE = 1'b0
) (
   input  logic [1:0]  width_i,
   input  logic        msbFirst_i,
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   // Bits within a byte are always MSB first, so only whole bytes move.
   // The 32-bit byte swap is its own inverse; the 16-bit and 8-bit cases
   // differ between directions because the image is top-aligned while the
   // register word is bottom-aligned.
   always_comb begin
      word_o = 32'h0;
      if (!INVERSE) begin
         case (width_i)
            W32: word_o = msbFirst_i ? word_i
                        : {word_i[7:0], word_i[15:8], word_i[23:16], word_i[31:24]};
            W16: word_o = msbFirst_i ? {word_i[15:0], 16'h0}
                        : {word_i[7:0], word_i[15:8], 16'h0};
            default: word_o = {word_i[7:0], 24'h0};
         endcase
      end else begin
         case (width_i)
            W32: word_o = msbFirst_i ? word_i
                        : {word_i[7:0], word_i[15:8], word_i[23:16], word_i[31:24]};
            W16: word_o = msbFirst_i ? {16'h0, word_i[31:16]}
                        : {16'h0, word_i[23:16], word_i[31:24]};
            default: word_o = {24'h0, word_i[31:24]};
         endcase
      end
   end

endmodule

// File: rtl/spi_shifter.sv
// ----------------------------------------------------------------------------
// spi_shifter
// Bit-serial SPI mode 0 transfer engine behind the SPI data register. A
// one-cycle start while idle launches one full-duplex transfer of 8, 16 or
// 32 bits; the received word appears on data_rx when rdy returns high.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset (aborts any transfer)
//   bus  - spi_shifter_if.slave: fast, data_width, msbyte_first, start,
//          data_tx, miso in; data_rx, rdy, sclk, mosi out
// Parameters:
//   SLOW_HALF - sclk half period in clk cycles when fast=0 (>= 2)
//   FAST_HALF - sclk half period in clk cycles when fast=1 (>= 2)
// ----------------------------------------------------------------------------
module spi_shifter
   import spi_pkg::*;
#(
   parameter int unsigned SLOW_HALF = 64,
   parameter int unsigned FAST_HALF = 2
) (
   input  logic         clk,
   input  logic         rst,
   spi_shifter_if.slave bus
);

   localparam int HALF_W = 16;

   state_e            state_q, state_d;
   logic [HALF_W-1:0] halfCnt_q, halfCnt_d;
   logic [4:0]        bitCnt_q, bitCnt_d;
   logic              fast_q, fast_d;
   logic [1:0]        width_q, width_d;
   logic              msbFirst_q, msbFirst_d;
   logic [30:0]       txShift_q, txShift_d;
   logic [31:0]       rxShift_q, rxShift_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              rdy_q, rdy_d;
   logic [31:0]       dataRx_q, dataRx_d;

   logic [31:0]       txImage;
   logic [31:0]       rxImage;
   logic [31:0]       rxWord;
   logic [HALF_W-1:0] halfStart;
   logic [HALF_W-1:0] halfReload;

   // Transmit word turned into the MSB-first shift image; only consumed on
   // the start edge, so it may follow the live inputs.
   spi_byte_order #(.INVERSE(1'b0)) txOrder (
      .width_i    (bus.data_width),
      .msbFirst_i (bus.msbyte_first),
      .word_i     (bus.data_tx),
      .word_o     (txImage)
   );

   // Received bits sit at the bottom of rxShift_q with the first bit highest;
   // lift them to the top so the inverse reorder sees the same image layout.
   always_comb begin
      case (width_q)
         W32:     rxImage = rxShift_q;
         W16:     rxImage = {rxShift_q[15:0], 16'h0};
         default: rxImage = {rxShift_q[7:0], 24'h0};
      endcase
   end

   spi_byte_order #(.INVERSE(1'b1)) rxOrder (
      .width_i    (width_q),
      .msbFirst_i (msbFirst_q),
      .word_i     (rxImage),
      .word_o     (rxWord)
   );

   // Half-period reload: the first one comes from the live fast input at
   // start, later ones from the latched copy so mid-transfer changes do nothing.
   always_comb begin
      halfStart  = bus.fast ? HALF_W'(FAST_HALF - 1) : HALF_W'(SLOW_HALF - 1);
      halfReload = fast_q   ? HALF_W'(FAST_HALF - 1) : HALF_W'(SLOW_HALF - 1);
   end

   // Next-state logic. Each half period lasts exactly HALF cycles, so a
   // transfer keeps rdy low for 2*HALF*N cycles. mosi changes only on the
   // falling sclk edge (or at start), giving HALF cycles of setup before
   // each rising edge where miso is sampled.
   always_comb begin
      state_d    = state_q;
      halfCnt_d  = halfCnt_q;
      bitCnt_d   = bitCnt_q;
      fast_d     = fast_q;
      width_d    = width_q;
      msbFirst_d = msbFirst_q;
      txShift_d  = txShift_q;
      rxShift_d  = rxShift_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      rdy_d      = rdy_q;
      dataRx_d   = dataRx_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               fast_d     = bus.fast;
               width_d    = bus.data_width;
               msbFirst_d = bus.msbyte_first;
               txShift_d  = txImage[30:0];
               mosi_d     = txImage[31];
               bitCnt_d   = 5'(nbits(bus.data_width) - 6'd1);
               halfCnt_d  = halfStart;
               rdy_d      = 1'b0;
               state_d    = LOW;
            end
         end
         LOW: begin
            if (halfCnt_q == '0) begin
               sclk_d    = 1'b1;
               rxShift_d = {rxShift_q[30:0], bus.miso};
               halfCnt_d = halfReload;
               state_d   = HIGH;
            end else begin
               halfCnt_d = halfCnt_q - 1'b1;
            end
         end
         HIGH: begin
            if (halfCnt_q == '0) begin
               sclk_d = 1'b0;
               if (bitCnt_q == 5'd0) begin
                  rdy_d    = 1'b1;
                  mosi_d   = 1'b1;
                  dataRx_d = rxWord;
                  state_d  = IDLE;
               end else begin
                  bitCnt_d  = bitCnt_q - 5'd1;
                  mosi_d    = txShift_q[30];
                  txShift_d = {txShift_q[29:0], 1'b0};
                  halfCnt_d = halfReload;
                  state_d   = LOW;
               end
            end else begin
               halfCnt_d = halfCnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. Reset drops straight back to idle values and clears
   // data_rx, so an aborted transfer never leaks partial receive data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         halfCnt_q  <= '0;
         bitCnt_q   <= '0;
         fast_q     <= 1'b0;
         width_q    <= W8;
         msbFirst_q <= 1'b0;
         txShift_q  <= '0;
         rxShift_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b1;
         rdy_q      <= 1'b1;
         dataRx_q   <= '0;
      end else begin
         state_q    <= state_d;
         halfCnt_q  <= halfCnt_d;
         bitCnt_q   <= bitCnt_d;
         fast_q     <= fast_d;
         width_q    <= width_d;
         msbFirst_q <= msbFirst_d;
         txShift_q  <= txShift_d;
         rxShift_q  <= rxShift_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         rdy_q      <= rdy_d;
         dataRx_q   <= dataRx_d;
      end
   end

   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.rdy     = rdy_q;
   assign bus.data_rx = dataRx_q;

endmodule
